// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target: frame size, idle fill byte, FSM states.
package spi_pkg;

  localparam int          SPI_BITS      = 8;
  localparam logic [7:0]  SPI_IDLE_BYTE = 8'hFF;
  localparam int          SPI_CNT_W     = $clog2(SPI_BITS);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_tgt_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with rise/fall detection
// taken from the synchronized level and one extra history flop.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clock_in,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the pin through the synchronizer chain and keep the previous level.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target, MSB first, 8-bit frames, oversampled by clock_in.
// Internal side: one-deep tx buffer (load/ready) and rx byte with valid strobe.
module spi_target
  import spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = SPI_IDLE_BYTE
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       ssn_in,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] datain,
  input  logic       load,
  output logic       ready,
  output logic [7:0] dataout,
  output logic       valid,
  output logic       underrun
);

  localparam logic [SPI_CNT_W-1:0] LAST_BIT = SPI_CNT_W'(SPI_BITS - 1);

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic ssn_lvl_unused, ssn_rise, ssn_fall;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clock_in (clock_in),
    .reset    (reset),
    .din      (sclk),
    .dout     (sclk_lvl_unused),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ssn (
    .clock_in (clock_in),
    .reset    (reset),
    .din      (ssn_in),
    .dout     (ssn_lvl_unused),
    .rise     (ssn_rise),
    .fall     (ssn_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clock_in (clock_in),
    .reset    (reset),
    .din      (mosi),
    .dout     (mosi_sync),
    .rise     (mosi_rise_unused),
    .fall     (mosi_fall_unused)
  );

  spi_tgt_state_t       state_q, state_d;
  logic [SPI_CNT_W-1:0] bit_cnt;
  logic [7:0]           tx_buf, tx_shift, rx_shift, tx_next, rx_in;
  logic                 tx_full;
  logic                 frame_start, frame_end, sample, launch, byte_done, take;

  // State register.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and per-cycle event decode; sclk edges coinciding with any
  // ssn edge are dropped.
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    sample      = 1'b0;
    launch      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ssn_fall) begin
          state_d     = ACTIVE;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (ssn_rise) begin
          state_d   = IDLE;
          frame_end = 1'b1;
        end else if (!ssn_fall) begin
          sample = sclk_rise;
          launch = sclk_fall;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_done = sample && (bit_cnt == LAST_BIT);
  assign take      = frame_start || byte_done;
  assign tx_next   = tx_full ? tx_buf : IDLE_BYTE;
  assign rx_in     = {rx_shift[6:0], mosi_sync};
  assign ready     = ~tx_full;

  // Transmit buffer: a load is only accepted while empty; a consumption in the
  // same cycle as an accepted load has already taken IDLE_BYTE.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      tx_buf  <= '0;
      tx_full <= 1'b0;
    end else if (load && !tx_full) begin
      tx_buf  <= datain;
      tx_full <= 1'b1;
    end else if (take) begin
      tx_full <= 1'b0;
    end
  end

  // Shift registers, bit counter, miso drive and the one-cycle strobes.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      dataout  <= '0;
      valid    <= 1'b0;
      underrun <= 1'b0;
      miso     <= 1'b0;
      miso_oe  <= 1'b0;
    end else begin
      valid    <= 1'b0;
      underrun <= 1'b0;
      if (take) begin
        tx_shift <= tx_next;
        underrun <= ~tx_full;
      end
      if (frame_start) begin
        bit_cnt <= '0;
        miso    <= tx_next[7];
        miso_oe <= 1'b1;
      end
      if (frame_end) begin
        bit_cnt <= '0;
        miso    <= 1'b0;
        miso_oe <= 1'b0;
      end
      if (sample) begin
        rx_shift <= rx_in;
        if (byte_done) begin
          dataout <= rx_in;
          valid   <= 1'b1;
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      // A zero count means a fresh byte was just loaded: present its MSB as is.
      if (launch) begin
        if (bit_cnt != '0) begin
          tx_shift <= {tx_shift[6:0], 1'b0};
          miso     <= tx_shift[6];
        end else begin
          miso <= tx_shift[7];
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// Scoreboard bench for spi_target: a mode-0 master at clock_in/8 drives frames,
// expected rx bytes are queued and checked by a monitor on each valid pulse.
module tb_spi_target;

  logic       clock_in = 1'b0;
  logic       reset    = 1'b1;
  logic       sclk     = 1'b0;
  logic       mosi     = 1'b0;
  logic       ssn_in   = 1'b1;
  logic       miso, miso_oe, ready, valid, underrun;
  logic [7:0] datain   = 8'h00;
  logic       load     = 1'b0;
  logic [7:0] dataout;

  int         n_vec = 0;
  int         n_err = 0;
  int         ur_cnt = 0;
  logic [7:0] exp_rx[$];

  spi_target #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .clock_in (clock_in),
    .reset    (reset),
    .sclk     (sclk),
    .mosi     (mosi),
    .ssn_in   (ssn_in),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .datain   (datain),
    .load     (load),
    .ready    (ready),
    .dataout  (dataout),
    .valid    (valid),
    .underrun (underrun)
  );

  always #5 clock_in = ~clock_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every valid pulse; count underrun pulses and
  // reject strobes that last longer than one cycle.
  logic valid_d = 1'b0, ur_d = 1'b0;
  always @(negedge clock_in) begin
    if (valid) begin
      if (exp_rx.size() == 0) chk("unexpected_valid", {24'h0, dataout}, 32'hxx);
      else chk("rx_byte", {24'h0, dataout}, {24'h0, exp_rx.pop_front()});
    end
    if (valid && valid_d) chk("valid_width", 32'd2, 32'd1);
    if (underrun && ur_d) chk("underrun_width", 32'd2, 32'd1);
    if (underrun) ur_cnt++;
    valid_d <= valid;
    ur_d    <= underrun;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock_in);
  endtask

  task automatic do_load(input logic [7:0] d);
    @(negedge clock_in);
    datain = d;
    load   = 1'b1;
    @(negedge clock_in);
    load   = 1'b0;
  endtask

  task automatic ssn_lo();
    @(negedge clock_in);
    ssn_in = 1'b0;
    cyc(6);
  endtask

  task automatic ssn_hi();
    cyc(4);
    ssn_in = 1'b1;
    cyc(6);
  endtask

  // Mode 0: data set while sclk low, both sides sample on the rising edge.
  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      cyc(4);
      sclk = 1'b1;
      rx   = {rx[6:0], miso};
      cyc(4);
      sclk = 1'b0;
    end
  endtask

  logic [7:0] got;
  int         ur0;

  initial begin
    cyc(3);
    reset = 1'b0;
    cyc(2);
    chk("rst_ready",    {31'h0, ready},    32'd1);
    chk("rst_miso",     {31'h0, miso},     32'd0);
    chk("rst_miso_oe",  {31'h0, miso_oe},  32'd0);
    chk("rst_dataout",  {24'h0, dataout},  32'h00);
    chk("rst_valid",    {31'h0, valid},    32'd0);
    chk("rst_underrun", {31'h0, underrun}, 32'd0);

    // 1: empty buffer, master sends A5, sees idle byte
    ur0 = ur_cnt;
    ssn_lo();
    chk("t1_ur_start", ur_cnt - ur0, 32'd1);
    chk("t1_miso_oe",  {31'h0, miso_oe}, 32'd1);
    exp_rx.push_back(8'hA5);
    spi_byte(8'hA5, 8, got);
    chk("t1_miso_byte", {24'h0, got}, 32'hFF);
    ssn_hi();
    chk("t1_ur_total", ur_cnt - ur0, 32'd2);
    chk("t1_miso_oe_off", {31'h0, miso_oe}, 32'd0);

    // 2: preload 3C, master sends 00
    do_load(8'h3C);
    chk("t2_ready_lo", {31'h0, ready}, 32'd0);
    ur0 = ur_cnt;
    ssn_lo();
    chk("t2_ready_hi", {31'h0, ready}, 32'd1);
    chk("t2_ur_start", ur_cnt - ur0, 32'd0);
    exp_rx.push_back(8'h00);
    spi_byte(8'h00, 8, got);
    chk("t2_miso_byte", {24'h0, got}, 32'h3C);
    ssn_hi();

    // 3: two bytes in one frame, only the first tx byte preloaded
    do_load(8'h5A);
    ur0 = ur_cnt;
    ssn_lo();
    chk("t3_ur_start", ur_cnt - ur0, 32'd0);
    exp_rx.push_back(8'h12);
    spi_byte(8'h12, 8, got);
    chk("t3_miso_b0", {24'h0, got}, 32'h5A);
    chk("t3_ur_mid", ur_cnt - ur0, 32'd1);
    exp_rx.push_back(8'h34);
    spi_byte(8'h34, 8, got);
    chk("t3_miso_b1", {24'h0, got}, 32'hFF);
    ssn_hi();
    chk("t3_dataout", {24'h0, dataout}, 32'h34);

    // 4: frame aborted after 5 bits, then a clean C3 frame
    ssn_lo();
    spi_byte(8'hE7, 5, got);
    ssn_hi();
    chk("t4_dataout_kept", {24'h0, dataout}, 32'h34);
    chk("t4_miso_oe_off",  {31'h0, miso_oe}, 32'd0);
    chk("t4_miso_off",     {31'h0, miso},    32'd0);
    ssn_lo();
    exp_rx.push_back(8'hC3);
    spi_byte(8'hC3, 8, got);
    ssn_hi();
    chk("t4_dataout", {24'h0, dataout}, 32'hC3);

    // 5: second load while full is ignored
    do_load(8'h55);
    do_load(8'h77);
    chk("t5_ready_lo", {31'h0, ready}, 32'd0);
    ssn_lo();
    exp_rx.push_back(8'h0F);
    spi_byte(8'h0F, 8, got);
    chk("t5_miso_byte", {24'h0, got}, 32'h55);
    ssn_hi();

    // 6: reset mid-byte, then a clean 81 frame
    do_load(8'h99);
    ssn_lo();
    spi_byte(8'hF0, 3, got);
    mosi  = 1'b1;
    reset = 1'b1;
    #1;
    chk("t6_rst_ready",    {31'h0, ready},    32'd1);
    chk("t6_rst_miso",     {31'h0, miso},     32'd0);
    chk("t6_rst_miso_oe",  {31'h0, miso_oe},  32'd0);
    chk("t6_rst_dataout",  {24'h0, dataout},  32'h00);
    chk("t6_rst_valid",    {31'h0, valid},    32'd0);
    chk("t6_rst_underrun", {31'h0, underrun}, 32'd0);
    sclk   = 1'b0;
    ssn_in = 1'b1;
    mosi   = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(3);
    ur0 = ur_cnt;
    ssn_lo();
    chk("t6_ur_start", ur_cnt - ur0, 32'd1);
    exp_rx.push_back(8'h81);
    spi_byte(8'h81, 8, got);
    chk("t6_miso_byte", {24'h0, got}, 32'hFF);
    ssn_hi();
    chk("t6_dataout", {24'h0, dataout}, 32'h81);

    cyc(4);
    chk("rx_queue_drained", exp_rx.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
